// File: rtl/bus_host_port_if.sv
// Host-port signal bundle: command channel in, peripheral bus out/in,
// response channel out. The master modport is the host port itself; the
// slave modport is the view of whatever sits around it (loader + device).
interface bus_host_port_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  // command channel
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [AddressWidth-1:0]   cmd_addr;
  logic                      cmd_we;
  logic [DataWidth/8-1:0]    cmd_be;
  logic [DataWidth-1:0]      cmd_wdata;
  // peripheral bus
  logic                      bus_req;
  logic [AddressWidth-1:0]   bus_addr;
  logic                      bus_we;
  logic [DataWidth/8-1:0]    bus_be;
  logic [DataWidth-1:0]      bus_wdata;
  logic                      bus_rvalid;
  logic [DataWidth-1:0]      bus_rdata;
  logic                      bus_err;
  // response channel
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DataWidth-1:0]      rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;
  logic                      stray;

  modport master (
    input  cmd_valid, cmd_addr, cmd_we, cmd_be, cmd_wdata,
    output cmd_ready,
    output bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_rvalid, bus_rdata, bus_err,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, stray,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_we, cmd_be, cmd_wdata,
    input  cmd_ready,
    input  bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_rvalid, bus_rdata, bus_err,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, stray,
    output rsp_ready
  );
endinterface

// File: rtl/bus_host_port.sv
// Single-outstanding bus initiator for the debug/test loader.
// Takes one command, issues one bus request pulse, waits for the device
// reply (or gives up after TimeoutCycles), and presents the result until
// the consumer takes it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// REQ   | bus_req high for exactly this cycle
// WAIT  | counting cycles until rvalid or timeout
// RSP   | rsp_valid high, result held until rsp_ready
module bus_host_port #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  bus_host_port_if.master    host_if
);

  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  if (DataWidth != 32) begin : g_dw_check
    $error("bus_host_port: only DataWidth = 32 is supported");
  end
  if (TimeoutCycles < 1) begin : g_to_check
    $error("bus_host_port: TimeoutCycles must be >= 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StRsp
  } state_e;

  state_e                    state_q;
  logic [CntW-1:0]           wait_cnt_q;
  logic                      cmd_ready_q;
  logic                      req_q;
  logic [AddressWidth-1:0]   addr_q;
  logic                      we_q;
  logic [DataWidth/8-1:0]    be_q;
  logic [DataWidth-1:0]      wdata_q;
  logic                      rsp_valid_q;
  logic [DataWidth-1:0]      rdata_q;
  logic                      err_q;
  logic                      timeout_q;
  logic                      stray_q;

  // Transaction sequencer; every output comes straight from a register here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      req_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      // A reply while not waiting (incl. a late one after a timeout) is
      // never consumed, only flagged until the next reset.
      if (host_if.bus_rvalid && (state_q != StWait)) begin
        stray_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (host_if.cmd_valid && cmd_ready_q) begin
            addr_q      <= host_if.cmd_addr;
            we_q        <= host_if.cmd_we;
            be_q        <= host_if.cmd_be;
            wdata_q     <= host_if.cmd_wdata;
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b1;
            state_q     <= StReq;
          end
        end

        StReq: begin
          req_q      <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end

        StWait: begin
          // A reply on the last counted cycle still beats the timeout.
          if (host_if.bus_rvalid) begin
            rdata_q     <= host_if.bus_rdata;
            err_q       <= host_if.bus_err;
            timeout_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end else if (wait_cnt_q == CntLast) begin
            rdata_q     <= '0;
            err_q       <= 1'b1;
            timeout_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        StRsp: begin
          if (host_if.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign host_if.cmd_ready   = cmd_ready_q;
  assign host_if.bus_req     = req_q;
  assign host_if.bus_addr    = addr_q;
  assign host_if.bus_we      = we_q;
  assign host_if.bus_be      = be_q;
  assign host_if.bus_wdata   = wdata_q;
  assign host_if.rsp_valid   = rsp_valid_q;
  assign host_if.rsp_rdata   = rdata_q;
  assign host_if.rsp_err     = err_q;
  assign host_if.rsp_timeout = timeout_q;
  assign host_if.stray       = stray_q;

endmodule
